// File: rtl/fifo_frame_pkg.sv
// fifo_frame_pkg: state and error encodings plus header sizing shared by the
// fifo_frame_reader slice.
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_LEN_ZERO = 2'd1,
        ERR_LEN_BIG  = 2'd2
    } err_code_t;

    // Number of FIFO words needed to carry one length field.
    function automatic int hdr_words_calc(input int len_width, input int data_width);
        return (len_width + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/fifo_frame_out_stage.sv
// fifo_frame_out_stage: one-entry registered valid/ready holding register for
// payload data with sop/eop flags.
module fifo_frame_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_sop   <= load_sop;
            m_eop   <= load_eop;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops a big-endian length header from an FWFT FIFO and forwards
// that many payload words as a sop/eop framed stream. Counters: FIFO_FRAME_READER_STATS_EN.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_LEN    = 1500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_has_data,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  err_len_zero,
    output logic                  err_len_big,
    output logic [31:0]           frame_count,
    output logic [31:0]           drop_count
);

    localparam int HDR_WORDS = hdr_words_calc(LEN_WIDTH, DATA_WIDTH);
    localparam int HDR_W     = HDR_WORDS * DATA_WIDTH;
    localparam int HCNT_W    = $clog2(HDR_WORDS + 1);

    state_t                state_q, state_d;
    logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  first_q, first_d;
    logic [HDR_W-1:0]      hdr_q, hdr_d, hdr_next;
    logic [LEN_WIDTH-1:0]  len;
    err_code_t             err_d;
    logic                  load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HDR;
            hcnt_q       <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            hdr_q        <= '0;
            err_len_zero <= 1'b0;
            err_len_big  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            hdr_q        <= hdr_d;
            err_len_zero <= (err_d == ERR_LEN_ZERO);
            err_len_big  <= (err_d == ERR_LEN_BIG);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        rem_d      = rem_q;
        first_d    = first_q;
        hdr_d      = hdr_q;
        err_d      = ERR_NONE;
        load       = 1'b0;
        fifo_rd_en = 1'b0;
        hdr_next   = (hdr_q << DATA_WIDTH) | HDR_W'(fifo_rd_data);
        len        = hdr_next[LEN_WIDTH-1:0];

        if (!rst) begin
            case (state_q)
                ST_HDR: begin
                    if (fifo_has_data) begin
                        fifo_rd_en = 1'b1;
                        hdr_d      = hdr_next;
                        if (hcnt_q == HCNT_W'(HDR_WORDS - 1)) begin
                            hcnt_d = '0;
                            if (len == '0) begin
                                err_d = ERR_LEN_ZERO;
                            end else if (32'(len) > 32'(MAX_LEN)) begin
                                err_d   = ERR_LEN_BIG;
                                rem_d   = len;
                                state_d = ST_DISCARD;
                            end else begin
                                rem_d   = len;
                                first_d = 1'b1;
                                state_d = ST_PAYLOAD;
                            end
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // A new word may enter only if the holding register empties this cycle.
                    load       = fifo_has_data && (!m_valid || m_ready);
                    fifo_rd_en = load;
                    if (load) begin
                        rem_d   = rem_q - 1'b1;
                        first_d = 1'b0;
                        if (rem_q == LEN_WIDTH'(1)) state_d = ST_HDR;
                    end
                end
                ST_DISCARD: begin
                    if (fifo_has_data) begin
                        fifo_rd_en = 1'b1;
                        rem_d      = rem_q - 1'b1;
                        if (rem_q == LEN_WIDTH'(1)) state_d = ST_HDR;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    fifo_frame_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(fifo_rd_data),
        .load_sop (first_q),
        .load_eop (rem_q == LEN_WIDTH'(1)),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_sop    (m_sop),
        .m_eop    (m_eop)
    );

`ifdef FIFO_FRAME_READER_STATS_EN
    logic [31:0] frame_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (m_valid && m_ready && m_eop) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (err_len_zero || err_len_big) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed bench for fifo_frame_reader with a queue-based
// FWFT FIFO in front and an acceptance recorder behind.
module tb_fifo_frame_reader;

`ifdef FIFO_FRAME_READER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_has_data;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sop;
    logic        m_eop;
    logic        err_len_zero;
    logic        err_len_big;
    logic [31:0] frame_count;
    logic [31:0] drop_count;

    fifo_frame_reader dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_has_data(fifo_has_data),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sop        (m_sop),
        .m_eop        (m_eop),
        .err_len_zero (err_len_zero),
        .err_len_big  (err_len_big),
        .frame_count  (frame_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0]  fq[$];
    logic [9:0]  outq[$];
    int          acc_cyc[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pops, valid_cyc, n_zero, n_big, t0;
    int          rd_viol  = 0;
    bit          toggle_mode = 1'b0;
    logic        s_rd_en;
    logic [11:0] s_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO head, sample at negedge, pop on the edge if requested.
    task automatic cycle();
        fifo_has_data = (fq.size() != 0) && (!toggle_mode || cyc[0] == 1'b0);
        fifo_rd_data  = fifo_has_data ? fq[0] : 8'h00;
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_vec   = {m_valid, m_data, m_sop, m_eop, fifo_rd_en};
        if (fifo_rd_en === 1'b1 && !fifo_has_data) rd_viol++;
        if (m_valid === 1'b1 && m_ready) begin
            outq.push_back({m_data, m_sop, m_eop});
            acc_cyc.push_back(cyc);
        end
        if (m_valid === 1'b1) valid_cyc++;
        if (err_len_zero === 1'b1) n_zero++;
        if (err_len_big === 1'b1) n_big++;
        @(posedge clk);
        if (s_rd_en === 1'b1 && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clr();
        outq.delete();
        acc_cyc.delete();
        pops = 0; valid_cyc = 0; n_zero = 0; n_big = 0;
    endtask

    task automatic push_frame3();
        fq.push_back(8'h00); fq.push_back(8'h03);
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1; fifo_has_data = 1'b0; fifo_rd_data = 8'h00;
        @(posedge clk); #1;
        clr();

        // Reset: FIFO holds data but nothing is popped; outputs at reset values.
        push_frame3();
        cycle();
        chk("rst_rd_en", 32'(s_rd_en), 32'd0);
        chk("rst_outputs", 32'(s_vec), 32'd0);
        chk("rst_no_pop", 32'(fq.size()), 32'd5);
        chk("rst_err", {30'd0, err_len_zero, err_len_big}, 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_drop_count", drop_count, 32'd0);

        // Frame len 3, m_ready high.
        rst = 1'b0; clr(); t0 = cyc;
        run(8);
        chk("f1_pops", 32'(pops), 32'd5);
        chk("f1_words", 32'(outq.size()), 32'd3);
        chk("f1_w0", 32'(outq[0]), {22'd0, 8'hA1, 2'b10});
        chk("f1_w1", 32'(outq[1]), {22'd0, 8'hA2, 2'b00});
        chk("f1_w2", 32'(outq[2]), {22'd0, 8'hA3, 2'b01});
        chk("f1_latency", 32'(acc_cyc[0] - t0), 32'd3);
        chk("f1_back2back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        chk("f1_frame_count", frame_count, 32'(STATS));

        // Same frame with a 4-cycle stall on A2.
        clr(); push_frame3();
        run(4);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("f2_stall%0d", i), 32'(s_vec), {20'd0, 1'b1, 8'hA2, 3'b000});
        end
        m_ready = 1'b1;
        run(6);
        chk("f2_words", 32'(outq.size()), 32'd3);
        chk("f2_w0", 32'(outq[0]), {22'd0, 8'hA1, 2'b10});
        chk("f2_w1", 32'(outq[1]), {22'd0, 8'hA2, 2'b00});
        chk("f2_w2", 32'(outq[2]), {22'd0, 8'hA3, 2'b01});
        chk("f2_pops", 32'(pops), 32'd5);
        chk("f2_frame_count", frame_count, 32'(2 * STATS));

        // Zero-length header, then len-1 frame.
        clr();
        fq.push_back(8'h00); fq.push_back(8'h00);
        fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h55);
        run(8);
        chk("z_err_zero", 32'(n_zero), 32'd1);
        chk("z_err_big", 32'(n_big), 32'd0);
        chk("z_words", 32'(outq.size()), 32'd1);
        chk("z_w0", 32'(outq[0]), {22'd0, 8'h55, 2'b11});
        chk("z_drop_count", drop_count, 32'(STATS));
        chk("z_frame_count", frame_count, 32'(3 * STATS));

        // Oversize header 0x05DD = 1501, then a len-2 frame.
        clr();
        fq.push_back(8'h05); fq.push_back(8'hDD);
        for (int i = 0; i < 1501; i++) fq.push_back(8'(i));
        fq.push_back(8'h00); fq.push_back(8'h02); fq.push_back(8'hB1); fq.push_back(8'hB2);
        for (int i = 0; i < 3000 && pops < 1503; i++) cycle();
        chk("big_pops", 32'(pops), 32'd1503);
        chk("big_valid_low", 32'(valid_cyc), 32'd0);
        chk("big_err_big", 32'(n_big), 32'd1);
        chk("big_err_zero", 32'(n_zero), 32'd0);
        run(8);
        chk("big_words", 32'(outq.size()), 32'd2);
        chk("big_w0", 32'(outq[0]), {22'd0, 8'hB1, 2'b10});
        chk("big_w1", 32'(outq[1]), {22'd0, 8'hB2, 2'b01});
        chk("big_drop_count", drop_count, 32'(2 * STATS));

        // Len-4 frame with has_data asserted every other cycle.
        clr(); toggle_mode = 1'b1;
        fq.push_back(8'h00); fq.push_back(8'h04);
        fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
        run(16);
        toggle_mode = 1'b0;
        chk("tg_pops", 32'(pops), 32'd6);
        chk("tg_words", 32'(outq.size()), 32'd4);
        chk("tg_w0", 32'(outq[0]), {22'd0, 8'hC1, 2'b10});
        chk("tg_w1", 32'(outq[1]), {22'd0, 8'hC2, 2'b00});
        chk("tg_w2", 32'(outq[2]), {22'd0, 8'hC3, 2'b00});
        chk("tg_w3", 32'(outq[3]), {22'd0, 8'hC4, 2'b01});
        chk("tg_rd_viol", 32'(rd_viol), 32'd0);
        chk("tg_frame_count", frame_count, 32'(5 * STATS));

        // Reset after 2 of 4 payload words; the remaining 0x00,0x01 become a header.
        clr();
        fq.push_back(8'h00); fq.push_back(8'h04);
        fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'h00); fq.push_back(8'h01);
        fq.push_back(8'h77);
        run(4);
        rst = 1'b1; m_ready = 1'b0;
        cycle();
        chk("mr_rd_en_in_rst", 32'(s_rd_en), 32'd0);
        rst = 1'b0; m_ready = 1'b1;
        cycle();
        chk("mr_after_rst", 32'(s_vec), 32'd1);
        run(5);
        chk("mr_words", 32'(outq.size()), 32'd2);
        chk("mr_w0", 32'(outq[0]), {22'd0, 8'hD1, 2'b10});
        chk("mr_w1", 32'(outq[1]), {22'd0, 8'h77, 2'b11});
        chk("mr_errs", 32'(n_zero + n_big), 32'd0);
        chk("mr_frame_count", frame_count, 32'(STATS));
        chk("mr_drop_count", drop_count, 32'd0);
        chk("mr_fifo_empty", 32'(fq.size()), 32'd0);
        chk("rd_en_without_data", 32'(rd_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Single-clock read-side stage that sits directly downstream of the FWFT asymmetric FIFO's narrow read port, in the read clock domain.
- Pops a big-endian length header of HDR_WORDS words, then forwards exactly that many payload words onto a registered valid/ready stream with sop/eop framing.
- Frames with a zero or oversize length are flagged, and their payload is discarded from the FIFO without being forwarded.

Parameters:
- DATA_WIDTH, 8, width of FIFO read word and output data.
- LEN_WIDTH, 16, payload length field width, in words.
- MAX_LEN, 1500, largest legal payload length; longer frames are discarded.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  synchronous, active-high reset.
- fifo_has_data  in  1  FIFO head word is valid (FWFT).
- fifo_rd_data  in  DATA_WIDTH  FIFO head word.
- fifo_rd_en  out  1  pop FIFO head this cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  payload word.
- m_sop  out  1  first payload word of frame.
- m_eop  out  1  last payload word of frame.
- err_len_zero  out  1  one-cycle pulse: header length 0.
- err_len_big  out  1  one-cycle pulse: header length > MAX_LEN.
- frame_count  out  32  frames forwarded (optional feature).
- drop_count  out  32  frames discarded (optional feature).

Behaviour:
- HDR_WORDS = ceil(LEN_WIDTH/DATA_WIDTH); default 2.
- Header words are shifted in MSB-first; length = low LEN_WIDTH bits of the assembled value, upper bits ignored.
- States: HDR (header word counter hcnt), PAYLOAD (remaining count rem), DISCARD (rem).
- HDR:
  - fifo_rd_en = fifo_has_data.
  - Each pop shifts the word in and increments hcnt.
  - On the last header pop, len is decoded:
    - len == 0: pulse err_len_zero, stay in HDR with hcnt = 0.
    - len > MAX_LEN: pulse err_len_big, rem = len, go to DISCARD.
    - otherwise: rem = len, first = 1, go to PAYLOAD.
- PAYLOAD:
  - load = fifo_has_data && (!m_valid || m_ready); fifo_rd_en = load.
  - On load, in the next cycle:
    - m_data = fifo_rd_data, m_valid = 1.
    - m_sop = first, m_eop = (rem == 1).
    - rem decrements and first clears.
  - If rem == 1 on load, go to HDR.
  - If m_valid && m_ready && !load, m_valid = 0.
- DISCARD:
  - fifo_rd_en = fifo_has_data; rem decrements on each pop.
  - Pop with rem == 1 returns to HDR.
  - Output is untouched.
- Output stage:
  - m_* are registered and stay stable while m_valid && !m_ready.
  - m_valid drops on acceptance whenever no new word is loaded in the same cycle, in any state.
  - A pending last word may still be held while the next header is being read.
- Latency: FIFO head word to m_data is 1 cycle. Back-to-back acceptance gives 1 word/cycle within a frame and HDR_WORDS bubble cycles between frames.
- fifo_rd_en is never asserted without fifo_has_data.
- Simultaneous m_ready and load: the old word is accepted and the new word is loaded in the same cycle, with no bubble.
- Reset values:
  - m_valid, m_sop, m_eop, err_* = 0; m_data = 0; counters = 0.
  - State HDR with hcnt = 0; fifo_rd_en = 0 while rst.
- Reset mid-frame: the partial frame and the held output word are dropped. The FIFO content is not flushed; the reader resumes by treating the next word as a header.

Optional Feature:
- FIFO_FRAME_READER_STATS_EN defined:
  - frame_count increments when a word with m_eop is accepted.
  - drop_count increments on each err_len_zero or err_len_big pulse.
  - Both counters wrap at 2^32 and are cleared by rst.
- Not defined: both counter outputs are constant 0 and no counter registers are built.

Decomposition:
- Package fifo_frame_pkg:
  - state encoding constants ST_HDR, ST_PAYLOAD, ST_DISCARD;
  - HDR_WORDS calculation function;
  - error-code constants.
- One natural sub-module, fifo_frame_out_stage: the one-entry registered valid/ready holding register carrying data, sop and eop.

Test Plan:
- Headers 0x00,0x03 then payload 0xA1,0xA2,0xA3, m_ready = 1:
  - three fifo_rd_en pops for the payload;
  - m_data A1(sop), A2, A3(eop) on consecutive cycles;
  - frame_count = 1.
- Same frame with m_ready held low for 4 cycles on A2:
  - A2 and flags held stable;
  - fifo_rd_en low while the output is full;
  - no word lost or duplicated.
- Header 0x00,0x00 followed by frame len 1 with payload 0x55:
  - one err_len_zero pulse;
  - next output is 0x55 with sop and eop both set;
  - drop_count = 1.
- Header 0x05,0xDD (len 1501) followed by 1501 bytes, then a len-2 frame:
  - err_len_big pulses once;
  - 1501 pops with m_valid low throughout;
  - then the len-2 frame is forwarded correctly.
- FIFO has_data toggles every other cycle during a len-4 frame:
  - pops only when has_data is set;
  - output sequence intact;
  - eop on the 4th word.
- rst asserted after 2 of 4 payload words:
  - next cycle m_valid = 0 and the state is HDR;
  - the remaining 2 payload words are interpreted as a header.
